color_poll_scheduler: RTL

Sequences periodic sensor reads for the colour-sensor datapath. When powered on, it walks the enabled channels (clear, red, green, blue, infrared) round-robin and issues one 16-bit read per channel to the I2C master over a req/ack handshake. It delivers each result on a per-channel data bus with a valid strobe, and reports bsy/nack to the status register logic. It sits between the config register outputs and the I2C master; its data outputs feed the channel registers.

---
 rtl/color_sensor_pkg.sv | 30 +++
 rtl/poll_period_timer.sv | 31 +++
 rtl/color_poll_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/color_sensor_pkg.sv
// Shared definitions for the colour-sensor polling datapath.
//   state_t      : poll scheduler FSM states
//   CH_*         : channel index constants (0=clear .. 4=infrared)
//   DEF_*        : default widths/counts used by the scheduler parameters
//   ch_addr()    : sensor sub-address of a channel (8-bit modulo arithmetic)
package color_sensor_pkg;

  localparam int DEF_REG_WIDTH = 16;
  localparam int DEF_CH_NUM    = 5;

  localparam int CH_CLEAR    = 0;
  localparam int CH_RED      = 1;
  localparam int CH_GREEN    = 2;
  localparam int CH_BLUE     = 3;
  localparam int CH_INFRARED = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SELECT      = 3'd1,
    REQ         = 3'd2,
    WAIT_ACK    = 3'd3,
    WAIT_PERIOD = 3'd4
  } state_t;

  // Channel i lives at base + 2*i; the sum wraps at 8 bits.
  function automatic logic [7:0] ch_addr(input logic [7:0] base, input logic [7:0] idx);
    return base + {idx[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/poll_period_timer.sv
// Loadable down-counter that paces the idle gap between polling rounds.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val into the counter (has priority over counting)
//   load_val  : value to load
//   expired   : 1 while the counter is at zero
// The counter decrements every cycle until it reaches zero, then holds.
module poll_period_timer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] load_val,
  output logic                    expired
);

  logic [PERIOD_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/color_poll_scheduler.sv
// Round-robin poll scheduler for the colour sensor.
// Walks the enabled channels, issues one read per channel to the I2C master
// over a req/ack handshake, retries NACKed reads, and publishes results.
//   clk, rst      : clock, asynchronous active-high reset
//   cfg_power_on  : polling enable
//   cfg_ch_en     : per-channel enable, sampled at each round start
//   cfg_period    : idle countdown between rounds
//   i2c_req/addr  : read request and sensor sub-address to the I2C master
//   i2c_ack/nack  : transaction done / sensor NACKed (valid with ack)
//   i2c_rdata     : read data, valid with ack when nack=0
//   ch_data       : latest word per channel (slot i at [REG_WIDTH*i +: REG_WIDTH])
//   ch_valid      : one-cycle update strobe per channel
//   round_done    : one-cycle pulse at the end of each round
//   bsy           : round in progress (SELECT, REQ, WAIT_ACK)
//   nack          : one-cycle pulse when a channel is dropped after retries
module color_poll_scheduler
  import color_sensor_pkg::*;
#(
  parameter int          REG_WIDTH    = DEF_REG_WIDTH,
  parameter int          CH_NUM       = DEF_CH_NUM,
  parameter int          PERIOD_WIDTH = 16,
  parameter logic [7:0]  ADDR_BASE    = 8'h14,
  parameter int          MAX_RETRY    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_power_on,
  input  logic [CH_NUM-1:0]           cfg_ch_en,
  input  logic [PERIOD_WIDTH-1:0]     cfg_period,
  output logic                        i2c_req,
  output logic [7:0]                  i2c_addr,
  input  logic                        i2c_ack,
  input  logic                        i2c_nack,
  input  logic [REG_WIDTH-1:0]        i2c_rdata,
  output logic [CH_NUM*REG_WIDTH-1:0] ch_data,
  output logic [CH_NUM-1:0]           ch_valid,
  output logic                        round_done,
  output logic                        bsy,
  output logic                        nack
);

  // Index must be able to hold CH_NUM (one past the last channel).
  localparam int IDX_W   = $clog2(CH_NUM + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CH_NUM-1:0]    r_en;
  logic [IDX_W-1:0]     r_idx;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_drop;
  logic                 r_req;
  logic [7:0]           r_addr;
  logic                 r_round_done;
  logic                 r_nack;
  logic [REG_WIDTH-1:0] r_slot  [CH_NUM];
  logic                 r_valid [CH_NUM];

  logic                 w_found;
  logic [IDX_W-1:0]     w_found_idx;
  logic                 w_expired;
  logic                 w_start;
  logic                 w_load;
  logic                 w_round_done;
  logic                 w_pick;
  logic                 w_issue;
  logic                 w_take;
  logic                 w_retry;
  logic                 w_give_up;
  logic                 w_discard;

  // Lowest enabled channel at or above the current index; descending scan so
  // the last hit wins, which is the lowest index.
  always_comb begin
    w_found     = 1'b0;
    w_found_idx = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (r_en[i] && (IDX_W'(i) >= r_idx)) begin
        w_found     = 1'b1;
        w_found_idx = IDX_W'(i);
      end
    end
  end

  poll_period_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (cfg_period),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_round_done = 1'b0;
    w_pick       = 1'b0;
    w_issue      = 1'b0;
    w_take       = 1'b0;
    w_retry      = 1'b0;
    w_give_up    = 1'b0;
    w_discard    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cfg_power_on) begin
          w_start      = 1'b1;
          w_state_next = SELECT;
        end
      end
      SELECT: begin
        if (!cfg_power_on) begin
          w_state_next = IDLE;
        end else if (w_found) begin
          w_pick       = 1'b1;
          w_state_next = REQ;
        end else begin
          w_round_done = 1'b1;
          w_load       = 1'b1;
          w_state_next = WAIT_PERIOD;
        end
      end
      REQ: begin
        if (!cfg_power_on) begin
          w_state_next = IDLE;
        end else begin
          w_issue      = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An in-flight transaction always runs to its ack; a power-off seen
        // at any point while waiting turns the result into a discard.
        if (i2c_ack) begin
          if (r_drop || !cfg_power_on) begin
            w_discard    = 1'b1;
            w_state_next = IDLE;
          end else if (!i2c_nack) begin
            w_take       = 1'b1;
            w_state_next = SELECT;
          end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
            w_retry      = 1'b1;
            w_state_next = REQ;
          end else begin
            w_give_up    = 1'b1;
            w_state_next = SELECT;
          end
        end
      end
      WAIT_PERIOD: begin
        if (!cfg_power_on) begin
          w_state_next = IDLE;
        end else if (w_expired) begin
          w_start      = 1'b1;
          w_state_next = SELECT;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en         <= '0;
      r_idx        <= '0;
      r_retry      <= '0;
      r_drop       <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_round_done <= 1'b0;
      r_nack       <= 1'b0;
    end else begin
      r_round_done <= w_round_done;
      r_nack       <= w_give_up;

      if (w_start) begin
        r_en  <= cfg_ch_en;
        r_idx <= '0;
      end else if (w_pick) begin
        r_idx <= w_found_idx;
      end else if (w_take || w_give_up) begin
        r_idx <= r_idx + 1'b1;
      end

      // Address is fixed at channel selection and reused for retries.
      if (w_pick) begin
        r_addr <= ch_addr(ADDR_BASE, 8'(w_found_idx));
      end

      if (w_issue) begin
        r_req <= 1'b1;
      end else if ((r_state == WAIT_ACK) && i2c_ack) begin
        r_req <= 1'b0;
      end

      if (w_retry) begin
        r_retry <= r_retry + 1'b1;
      end else if (w_take || w_give_up || w_discard || w_start) begin
        r_retry <= '0;
      end

      if ((r_state == WAIT_ACK) && !i2c_ack && !cfg_power_on) begin
        r_drop <= 1'b1;
      end else if (r_state != WAIT_ACK || i2c_ack) begin
        r_drop <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_slot[gi]  <= '0;
          r_valid[gi] <= 1'b0;
        end else begin
          r_valid[gi] <= w_take && (r_idx == IDX_W'(gi));
          if (w_take && (r_idx == IDX_W'(gi))) begin
            r_slot[gi] <= i2c_rdata;
          end
        end
      end
      assign ch_data[gi*REG_WIDTH +: REG_WIDTH] = r_slot[gi];
      assign ch_valid[gi]                       = r_valid[gi];
    end
  endgenerate

  assign i2c_req    = r_req;
  assign i2c_addr   = r_addr;
  assign round_done = r_round_done;
  assign nack       = r_nack;
  assign bsy        = (r_state == SELECT) || (r_state == REQ) || (r_state == WAIT_ACK);

endmodule
